imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction memory shared between CPU fetch and a bulk loader; the FSM stalls
// the CPU, opens a write window for the loader, then pulses the CPU reset.
module imem_load_ctrl #(
    parameter int AW        = 12,
    parameter int DRAIN_CYC = 2,
    parameter int RST_CYC   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] fetch_addr,
    output logic [31:0]   fetch_data,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          cpu_hold,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic [AW:0]   ld_count,
    output logic          err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          MAXC    = (DRAIN_CYC > RST_CYC) ? DRAIN_CYC : RST_CYC;
    localparam int          CW      = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          rstn_q;
    logic [31:0]   fetch_q;
    logic          rd_en;
    logic          wr_en;

    logic [31:0] mem [0:(1<<AW)-1];

    // Loader handshake: a beat transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_ready is high only while in LOAD.
    assign ld_ready  = (state_q == ST_LOAD);
    assign wr_en     = ld_valid && ld_ready;
    assign cpu_hold  = (state_q != ST_RUN);
    assign busy      = (state_q != ST_RUN);
    assign cpu_rst_n = rstn_q;
    assign fetch_data = fetch_q;
    assign ld_count  = cnt_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A start takes priority; a beat in the same cycle is dropped and flagged.
                rd_en = !ld_start;
                if (ld_start) begin
                    state_d = ST_DRAIN;
                    cyc_d   = '0;
                    cnt_d   = '0;
                    err_d   = ld_valid;
                end else if (ld_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (ld_valid) err_d = 1'b1;
                if (cyc_q == DRAIN_LAST) begin
                    state_d = ST_LOAD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + (AW+1)'(1);
                    if (ld_last) begin
                        state_d = ST_RELEASE;
                        cyc_d   = '0;
                    end
                end
            end
            ST_RELEASE: begin
                if (ld_valid) err_d = 1'b1;
                if (cyc_q == RST_LAST) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cyc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
            fetch_q <= NOP;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rstn_q  <= (state_d != ST_RELEASE);
            fetch_q <= rd_en ? mem[fetch_addr] : NOP;
        end
    end

    // RAM contents survive rst; the state reset above already blocks writes.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ld_addr] <= ld_data;
    end

endmodule
